// File: rtl/tz_local_time.sv
// UTC to local time converter. It applies the signed TZ offset captured from the edit screen
// and wraps the result modulo 24h. A three-pass FSM (MIN, HOUR, DONE) handles each request.
// Results, DayShift and err are registered at the DONE edge, and valid pulses in the cycle
// after that edge.
module tz_local_time #(
  parameter int unsigned MAX_TZ_HOURS = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [4:0] UTCHours,
  input  logic [5:0] UTCMinutes,
  input  logic [3:0] TZHours,
  input  logic [6:0] TZMinutes,
  input  logic       TZSign,
  output logic [4:0] LocalHours,
  output logic [5:0] LocalMinutes,
  output logic [1:0] DayShift,
  output logic       err,
  output logic       valid,
  output logic       busy
);

  localparam logic [3:0] MaxTzHours = 4'(MAX_TZ_HOURS);

  typedef enum logic [1:0] {StIdle, StMin, StHour, StDone} state_e;

  state_e            state_q;
  logic              pending_q;
  logic [4:0]        utc_hour_q;
  logic [5:0]        utc_min_q;
  logic [3:0]        tz_hour_q;
  logic [5:0]        tz_min_q;
  logic              sign_q;
  logic              bad_q;
  logic [5:0]        min_q;
  logic signed [1:0] carry_q;
  logic [4:0]        hour_q;
  logic [1:0]        day_q;

  logic              capture;
  logic signed [7:0] m_raw, m_adj;
  logic signed [1:0] carry_d;
  logic signed [6:0] h_raw, h_adj;
  logic [1:0]        day_d;
  logic              unused_bits;

  // A new snapshot is taken on a fresh request in IDLE, or at DONE when a request is queued.
  assign capture = ((state_q == StIdle) && update) ||
                   ((state_q == StDone) && (pending_q || update));
  assign busy    = (state_q != StIdle);

  // Minute stage: signed add/subtract with a single wrap and a -1/0/+1 carry.
  always_comb begin
    m_raw   = sign_q ? ($signed({2'b00, utc_min_q}) - $signed({2'b00, tz_min_q}))
                     : ($signed({2'b00, utc_min_q}) + $signed({2'b00, tz_min_q}));
    m_adj   = m_raw;
    carry_d = 2'sb00;
    if (!sign_q && (m_raw >= 8'sd60)) begin
      m_adj   = m_raw - 8'sd60;
      carry_d = 2'sb01;
    end else if (sign_q && (m_raw < 8'sd0)) begin
      m_adj   = m_raw + 8'sd60;
      carry_d = 2'sb11;
    end
  end

  // Hour stage: fold in the minute carry, wrap modulo 24 and report the day shift.
  always_comb begin
    h_raw = sign_q ? ($signed({2'b00, utc_hour_q}) - $signed({3'b000, tz_hour_q}))
                   : ($signed({2'b00, utc_hour_q}) + $signed({3'b000, tz_hour_q}));
    h_raw = h_raw + $signed({{5{carry_q[1]}}, carry_q});
    h_adj = h_raw;
    day_d = 2'b00;
    if (h_raw >= 7'sd24) begin
      h_adj = h_raw - 7'sd24;
      day_d = 2'b01;
    end else if (h_raw < 7'sd0) begin
      h_adj = h_raw + 7'sd24;
      day_d = 2'b11;
    end
  end

  // Only legal UTC inputs reach the outputs, so the wrapped results always fit in the
  // narrower result registers.
  assign unused_bits = ^{m_adj[7:6], h_adj[6:5]};

  // Input snapshot, with the TZ offset clamped to its legal range.
  always_ff @(posedge clk) begin
    if (reset) begin
      utc_hour_q <= '0;
      utc_min_q  <= '0;
      tz_hour_q  <= '0;
      tz_min_q   <= '0;
      sign_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else if (capture) begin
      utc_hour_q <= UTCHours;
      utc_min_q  <= UTCMinutes;
      tz_hour_q  <= (TZHours > MaxTzHours) ? MaxTzHours : TZHours;
      tz_min_q   <= (TZMinutes > 7'd59) ? 6'd59 : TZMinutes[5:0];
      sign_q     <= TZSign;
      bad_q      <= (UTCHours > 5'd23) || (UTCMinutes > 6'd59);
    end
  end

  // Conversion FSM with the pending-request flag, the stage registers and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      min_q        <= '0;
      carry_q      <= 2'sb00;
      hour_q       <= '0;
      day_q        <= '0;
      LocalHours   <= '0;
      LocalMinutes <= '0;
      DayShift     <= '0;
      err          <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (update) state_q <= StMin;
        end
        StMin: begin
          if (update) pending_q <= 1'b1;
          min_q   <= m_adj[5:0];
          carry_q <= carry_d;
          state_q <= StHour;
        end
        StHour: begin
          if (update) pending_q <= 1'b1;
          hour_q  <= h_adj[4:0];
          day_q   <= day_d;
          state_q <= StDone;
        end
        StDone: begin
          valid <= 1'b1;
          if (bad_q) begin
            err <= 1'b1;
          end else begin
            err          <= 1'b0;
            LocalHours   <= hour_q;
            LocalMinutes <= min_q;
            DayShift     <= day_q;
          end
          pending_q <= 1'b0;
          state_q   <= capture ? StMin : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tz_local_time.sv
// Self-checking bench for tz_local_time. Expected results come from a total-minutes model
// of the conversion.
module tb_tz_local_time;

  logic       clk;
  logic       reset;
  logic       update;
  logic [4:0] UTCHours;
  logic [5:0] UTCMinutes;
  logic [3:0] TZHours;
  logic [6:0] TZMinutes;
  logic       TZSign;
  logic [4:0] LocalHours;
  logic [5:0] LocalMinutes;
  logic [1:0] DayShift;
  logic       err;
  logic       valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference state: the last accepted result and the error flag.
  int       exp_h = 0;
  int       exp_m = 0;
  logic [1:0] exp_d = 2'b00;
  logic     exp_err = 1'b0;

  tz_local_time #(.MAX_TZ_HOURS(14)) dut (
    .clk         (clk),
    .reset       (reset),
    .update      (update),
    .UTCHours    (UTCHours),
    .UTCMinutes  (UTCMinutes),
    .TZHours     (TZHours),
    .TZMinutes   (TZMinutes),
    .TZSign      (TZSign),
    .LocalHours  (LocalHours),
    .LocalMinutes(LocalMinutes),
    .DayShift    (DayShift),
    .err         (err),
    .valid       (valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: convert both times to minutes of the day, add the signed offset, and wrap once.
  task automatic model_conv(input int uh, input int um, input int tzh, input int tzm,
                            input bit sign);
    int off, total;
    if (uh > 23 || um > 59) begin
      exp_err = 1'b1;
      return;
    end
    if (tzh > 14) tzh = 14;
    if (tzm > 59) tzm = 59;
    off   = tzh * 60 + tzm;
    total = uh * 60 + um + (sign ? -off : off);
    exp_err = 1'b0;
    exp_d   = 2'b00;
    if (total >= 1440) begin
      total -= 1440;
      exp_d = 2'b01;
    end else if (total < 0) begin
      total += 1440;
      exp_d = 2'b11;
    end
    exp_h = total / 60;
    exp_m = total % 60;
  endtask

  task automatic set_inputs(input int uh, input int um, input int tzh, input int tzm,
                            input bit sign);
    UTCHours   = 5'(uh);
    UTCMinutes = 6'(um);
    TZHours    = 4'(tzh);
    TZMinutes  = 7'(tzm);
    TZSign     = sign;
  endtask

  // Stimulus only: pulse update for edge N and return #1 after edge N+3.
  task automatic run_conv(input int uh, input int um, input int tzh, input int tzm,
                          input bit sign);
    @(negedge clk);
    set_inputs(uh, um, tzh, tzm, sign);
    update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    update = 1'b0;
    set_inputs(10, 10, 3, 3, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({LocalHours, LocalMinutes, DayShift, err, valid, busy} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {LocalHours, LocalMinutes, DayShift, err, valid, busy});
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({LocalHours, LocalMinutes, DayShift, err, valid, busy} !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0",
               {LocalHours, LocalMinutes, DayShift, err, valid, busy});
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    set_inputs(10, 30, 7, 0, 0);
    update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_early: got %b want 0", valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || LocalHours !== 5'd17 || LocalMinutes !== 6'd30 ||
        DayShift !== 2'b00 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got v%b %0d:%0d d%b e%b want v1 17:30 d00 e0",
               valid, LocalHours, LocalMinutes, DayShift, err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_fall: got %b want 0", valid);
    end
    model_conv(10, 30, 7, 0, 0);
  endtask

  task automatic test_boundaries;
    int cases[5][8] = '{
      '{23, 59, 14, 59, 0, 14, 58, 1},
      '{23, 59, 15, 59, 0, 14, 58, 1},
      '{ 0,  0, 14, 59, 1,  9,  1, 3},
      '{12,  0,  0,  0, 1, 12,  0, 0},
      '{ 1,  0,  0, 100, 0, 1, 59, 0}
    };
    for (int i = 0; i < 5; i++) begin
      run_conv(cases[i][0], cases[i][1], cases[i][2], cases[i][3], cases[i][4] != 0);
      model_conv(cases[i][0], cases[i][1], cases[i][2], cases[i][3], cases[i][4] != 0);
      checks++;
      if (valid !== 1'b1 || LocalHours !== 5'(cases[i][5]) ||
          LocalMinutes !== 6'(cases[i][6]) || DayShift !== 2'(cases[i][7]) || err !== 1'b0)
      begin
        errors++;
        $display("FAIL boundary_%0d: got v%b %0d:%0d d%b e%b want v1 %0d:%0d d%0d e0", i,
                 valid, LocalHours, LocalMinutes, DayShift, err,
                 cases[i][5], cases[i][6], cases[i][7]);
      end
    end
  endtask

  task automatic test_invalid;
    run_conv(5, 20, 3, 10, 0);
    model_conv(5, 20, 3, 10, 0);
    run_conv(24, 5, 1, 0, 0);
    model_conv(24, 5, 1, 0, 0);
    checks++;
    if (valid !== 1'b1 || err !== 1'b1 || LocalHours !== 5'd8 || LocalMinutes !== 6'd30 ||
        DayShift !== 2'b00) begin
      errors++;
      $display("FAIL invalid_utc: got v%b e%b %0d:%0d d%b want v1 e1 8:30 d00",
               valid, err, LocalHours, LocalMinutes, DayShift);
    end
    run_conv(6, 60, 0, 0, 0);
    model_conv(6, 60, 0, 0, 0);
    checks++;
    if (valid !== 1'b1 || err !== 1'b1 || LocalHours !== 5'd8) begin
      errors++;
      $display("FAIL invalid_min: got v%b e%b h%0d want v1 e1 h8", valid, err, LocalHours);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_inputs(8, 15, 1, 0, 0);
    update = 1'b1;
    @(posedge clk);                   // edge N
    #1 set_inputs(8, 15, 2, 0, 0);    // update stays high for N+1 and N+2
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) update = 1'b0;
      if (k <= 5) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy_%0d: got %b want 1", k, busy);
        end
      end
      if (k == 3) begin
        model_conv(8, 15, 1, 0, 0);
        checks++;
        if (valid !== 1'b1 || LocalHours !== 5'(exp_h) || LocalMinutes !== 6'(exp_m)) begin
          errors++;
          $display("FAIL b2b_first: got v%b %0d:%0d want v1 %0d:%0d",
                   valid, LocalHours, LocalMinutes, exp_h, exp_m);
        end
      end else if (k == 6) begin
        model_conv(8, 15, 2, 0, 0);
        checks++;
        if (valid !== 1'b1 || LocalHours !== 5'(exp_h) || LocalMinutes !== 6'(exp_m)) begin
          errors++;
          $display("FAIL b2b_second: got v%b %0d:%0d want v1 %0d:%0d",
                   valid, LocalHours, LocalMinutes, exp_h, exp_m);
        end
      end else begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_valid_%0d: got %b want 0", k, valid);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy %b want 0", busy);
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    set_inputs(20, 45, 5, 30, 0);
    update = 1'b1;
    @(posedge clk);                    // edge N
    repeat (2) @(posedge clk);
    #1 set_inputs(3, 10, 4, 20, 1);    // sampled at the N+3 DONE edge
    @(posedge clk);
    #1 update = 1'b0;
    model_conv(20, 45, 5, 30, 0);
    checks++;
    if (valid !== 1'b1 || LocalHours !== 5'(exp_h) || LocalMinutes !== 6'(exp_m) ||
        DayShift !== exp_d) begin
      errors++;
      $display("FAIL hold_first: got v%b %0d:%0d d%b want v1 %0d:%0d d%b",
               valid, LocalHours, LocalMinutes, DayShift, exp_h, exp_m, exp_d);
    end
    repeat (3) @(posedge clk);
    #1;
    model_conv(3, 10, 4, 20, 1);
    checks++;
    if (valid !== 1'b1 || LocalHours !== 5'(exp_h) || LocalMinutes !== 6'(exp_m) ||
        DayShift !== exp_d) begin
      errors++;
      $display("FAIL hold_second: got v%b %0d:%0d d%b want v1 %0d:%0d d%b",
               valid, LocalHours, LocalMinutes, DayShift, exp_h, exp_m, exp_d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int uh, um, tzh, tzm;
    bit sign;
    for (int i = 0; i < 40; i++) begin
      uh   = ($urandom_range(0, 7) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      um   = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      tzh  = $urandom_range(0, 15);
      tzm  = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59);
      sign = 1'($urandom_range(0, 1));
      run_conv(uh, um, tzh, tzm, sign);
      model_conv(uh, um, tzh, tzm, sign);
      checks++;
      if (valid !== 1'b1 || err !== exp_err || LocalHours !== 5'(exp_h) ||
          LocalMinutes !== 6'(exp_m) || DayShift !== exp_d) begin
        errors++;
        $display("FAIL rand_%0d: in %0d:%0d %s%0d:%0d got v%b e%b %0d:%0d d%b want v1 e%b %0d:%0d d%b",
                 i, uh, um, sign ? "-" : "+", tzh, tzm, valid, err, LocalHours,
                 LocalMinutes, DayShift, exp_err, exp_h, exp_m, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_inputs(11, 11, 2, 2, 0);
    update = 1'b1;
    @(posedge clk);          // edge N
    #1 update = 1'b0;
    @(posedge clk);          // N+1: now in HOUR
    #1 reset = 1'b1;
    @(posedge clk);          // N+2
    #1 reset = 1'b0;
    exp_h = 0; exp_m = 0; exp_d = 2'b00; exp_err = 1'b0;
    checks++;
    if ({LocalHours, LocalMinutes, DayShift, err, valid, busy} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {LocalHours, LocalMinutes, DayShift, err, valid, busy});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || LocalHours !== 5'd0) begin
        errors++;
        $display("FAIL reset_mid_novalid_%0d: got v%b h%0d want v0 h0", k, valid, LocalHours);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    update = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_boundaries();
    test_invalid();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
